// File: rtl/ps2_key_transmitter.sv
// ---------------------------------------------------------------------------
// Module  : ps2_key_transmitter
// Brief   : Keyboard-side PS/2 transmitter. Expands a game key code into its
//           set-2 scancode sequence and serialises each byte as a
//           device-to-host frame on generated PS/2 clock/data lines.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_key_transmitter #(
  parameter int HALF_PERIOD = 1000,
  parameter int BYTE_GAP    = 2500
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_code,
  input  logic       i_code_valid,
  output logic       o_busy,
  output logic       o_ps2_clk,
  output logic       o_ps2_data,
  output logic       o_done,
  output logic       o_err
);

  localparam logic [15:0] HALF_LOAD = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(BYTE_GAP - 1);
  localparam logic [3:0]  LAST_BIT  = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_BIT_HIGH = 3'd2,
    S_BIT_LOW  = 3'd3,
    S_GAP      = 3'd4,
    S_DONE     = 3'd5,
    S_REJECT   = 3'd6
  } state_t;

  state_t      state;
  logic [7:0]  code_q;
  logic [7:0]  byte0, byte1, byte2;
  logic [1:0]  byte_cnt;
  logic [1:0]  byte_idx;
  logic [3:0]  bit_idx;
  logic [15:0] phase_cnt;

  logic        lut_ok;
  logic [1:0]  lut_cnt;
  logic [7:0]  lut_b0, lut_b1, lut_b2;
  logic [7:0]  make_code;
  logic [7:0]  cur_byte;

  // Frame bit order: start 0, data LSB first, odd parity, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic bit_v;
    case (idx)
      4'd0:    bit_v = 1'b0;
      4'd9:    bit_v = ~^b;
      4'd10:   bit_v = 1'b1;
      default: bit_v = b[idx[2:0] - 3'd1];
    endcase
    return bit_v;
  endfunction

  // Release bit is stripped first; keys 04..07 live in the extended (E0) space.
  always_comb begin
    make_code = 8'h00;
    lut_ok    = 1'b0;
    lut_cnt   = 2'd0;
    lut_b0    = 8'h00;
    lut_b1    = 8'h00;
    lut_b2    = 8'h00;
    case (code_q[6:0])
      7'h00:        make_code = 8'h1D;
      7'h01:        make_code = 8'h1B;
      7'h02:        make_code = 8'h1C;
      7'h03:        make_code = 8'h23;
      7'h10:        make_code = 8'h5A;
      7'h11:        make_code = 8'h29;
      7'h04, 7'h14: make_code = 8'h75;
      7'h05, 7'h15: make_code = 8'h72;
      7'h06, 7'h16: make_code = 8'h6B;
      7'h07, 7'h17: make_code = 8'h74;
      default:      make_code = 8'h00;
    endcase
    if (make_code != 8'h00) begin
      if (code_q[3:2] == 2'b01) begin
        if (!code_q[7]) begin
          lut_ok = 1'b1;
          lut_b0 = 8'hE0;
          if (code_q[4]) begin
            lut_cnt = 2'd3;
            lut_b1  = 8'hF0;
            lut_b2  = make_code;
          end else begin
            lut_cnt = 2'd2;
            lut_b1  = make_code;
          end
        end
      end else if (code_q[7]) begin
        lut_ok  = 1'b1;
        lut_cnt = 2'd2;
        lut_b0  = 8'hF0;
        lut_b1  = make_code;
      end else begin
        lut_ok  = 1'b1;
        lut_cnt = 2'd1;
        lut_b0  = make_code;
      end
    end
  end

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = byte0;
      2'd1:    cur_byte = byte1;
      default: cur_byte = byte2;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      code_q     <= 8'h00;
      byte0      <= 8'h00;
      byte1      <= 8'h00;
      byte2      <= 8'h00;
      byte_cnt   <= 2'd0;
      byte_idx   <= 2'd0;
      bit_idx    <= 4'd0;
      phase_cnt  <= 16'd0;
      o_busy     <= 1'b0;
      o_ps2_clk  <= 1'b1;
      o_ps2_data <= 1'b1;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_code_valid) begin
            code_q <= i_code;
            o_busy <= 1'b1;
            state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (lut_ok) begin
            byte0      <= lut_b0;
            byte1      <= lut_b1;
            byte2      <= lut_b2;
            byte_cnt   <= lut_cnt;
            byte_idx   <= 2'd0;
            bit_idx    <= 4'd0;
            phase_cnt  <= HALF_LOAD;
            o_ps2_data <= 1'b0;
            state      <= S_BIT_HIGH;
          end else begin
            o_err <= 1'b1;
            state <= S_REJECT;
          end
        end
        S_REJECT: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        S_BIT_HIGH: begin
          if (phase_cnt == 16'd0) begin
            o_ps2_clk <= 1'b0;
            phase_cnt <= HALF_LOAD;
            state     <= S_BIT_LOW;
          end else begin
            phase_cnt <= phase_cnt - 16'd1;
          end
        end
        S_BIT_LOW: begin
          if (phase_cnt == 16'd0) begin
            o_ps2_clk <= 1'b1;
            if (bit_idx == LAST_BIT) begin
              o_ps2_data <= 1'b1;
              bit_idx    <= 4'd0;
              if (byte_idx != byte_cnt - 2'd1) begin
                byte_idx  <= byte_idx + 2'd1;
                phase_cnt <= GAP_LOAD;
                state     <= S_GAP;
              end else begin
                o_done <= 1'b1;
                state  <= S_DONE;
              end
            end else begin
              bit_idx    <= bit_idx + 4'd1;
              o_ps2_data <= frame_bit(cur_byte, bit_idx + 4'd1);
              phase_cnt  <= HALF_LOAD;
              state      <= S_BIT_HIGH;
            end
          end else begin
            phase_cnt <= phase_cnt - 16'd1;
          end
        end
        S_GAP: begin
          if (phase_cnt == 16'd0) begin
            o_ps2_data <= 1'b0;
            phase_cnt  <= HALF_LOAD;
            state      <= S_BIT_HIGH;
          end else begin
            phase_cnt <= phase_cnt - 16'd1;
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
